// File: rtl/q_update_ctrl.sv
// q_update_ctrl: sequences one Q-learning update against an external Q-table RAM.
// The block reads Q(s,a) and every Q(s',a'), then finds the max and the greedy action.
// It then applies the QUpdater arithmetic and writes the new Q(s,a) back.

// QUpdater datapath: new = old + ((r + 7/8*max - old) >> 1), all modulo 2^16.
module q_updater #(
    parameter int D_W = 16
) (
    input  logic [D_W-1:0] old_i,
    input  logic [D_W-1:0] max_i,
    input  logic [D_W-1:0] reward_i,
    output logic [D_W-1:0] new_o
);
    logic [D_W-1:0] c;

    // Temporal-difference term and half-step update, both wrapping with no saturation
    always_comb begin
        c     = reward_i + (max_i >> 1) + (max_i >> 2) + (max_i >> 3) - old_i;
        new_o = old_i + (c >> 1);
    end
endmodule

module q_update_ctrl #(
    parameter int S_W = 4,
    parameter int A_W = 2,
    parameter int D_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [S_W-1:0]     cur_state,
    input  logic [A_W-1:0]     action,
    input  logic [S_W-1:0]     next_state,
    input  logic [D_W-1:0]     reward,
    output logic [S_W+A_W-1:0] mem_addr,
    output logic               mem_rd_en,
    input  logic [D_W-1:0]     mem_rdata,
    output logic               mem_wr_en,
    output logic [D_W-1:0]     mem_wdata,
    output logic               busy,
    output logic               done,
    output logic [D_W-1:0]     q_out,
    output logic [A_W-1:0]     best_action
);
    localparam int N_ACT = 1 << A_W;
    localparam int K_W   = A_W + 1;   // read index spans 0..N_ACT

    typedef enum logic [2:0] {IDLE, RD, LAST, CALC, WR} state_t;

    state_t             state_q;
    logic [K_W-1:0]     k_q;
    logic [S_W-1:0]     cur_q;
    logic [A_W-1:0]     act_q;
    logic [S_W-1:0]     nxt_q;
    logic [D_W-1:0]     rew_q;
    logic [D_W-1:0]     old_q;
    logic [D_W-1:0]     max_q;
    logic [A_W-1:0]     best_q;

    logic [S_W+A_W-1:0] addr_q;
    logic               rd_en_q;
    logic               wr_en_q;
    logic [D_W-1:0]     wdata_q;
    logic               busy_q;
    logic               done_q;
    logic [D_W-1:0]     q_out_q;
    logic [A_W-1:0]     best_out_q;

    logic               rd_live;
    logic [K_W-1:0]     rd_idx;
    logic [D_W-1:0]     new_q_d;

    // Which read index is landing on mem_rdata this cycle (reads return one cycle after issue)
    always_comb begin
        rd_live = 1'b0;
        rd_idx  = '0;
        if (state_q == RD && k_q != '0) begin
            rd_live = 1'b1;
            rd_idx  = k_q - K_W'(1);
        end else if (state_q == LAST) begin
            rd_live = 1'b1;
            rd_idx  = K_W'(N_ACT);
        end
    end

    q_updater #(.D_W(D_W)) u_upd (
        .old_i    (old_q),
        .max_i    (max_q),
        .reward_i (rew_q),
        .new_o    (new_q_d)
    );

    // Sequencer FSM with registered RAM strobes and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cur_q      <= '0;
            act_q      <= '0;
            nxt_q      <= '0;
            rew_q      <= '0;
            old_q      <= '0;
            max_q      <= '0;
            best_q     <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_out_q    <= '0;
            best_out_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;

            // Returning read data: old value first, then a running strict-greater max,
            // so ties keep the lowest action index
            if (rd_live) begin
                if (rd_idx == K_W'(0)) begin
                    old_q <= mem_rdata;
                end else if (rd_idx == K_W'(1)) begin
                    max_q  <= mem_rdata;
                    best_q <= '0;
                end else if (mem_rdata > max_q) begin
                    max_q  <= mem_rdata;
                    best_q <= rd_idx[A_W-1:0] - A_W'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q   <= cur_state;
                        act_q   <= action;
                        nxt_q   <= next_state;
                        rew_q   <= reward;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        addr_q  <= {cur_state, action};
                        state_q <= RD;
                    end
                end
                RD: begin
                    if (k_q == K_W'(N_ACT)) begin
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                        state_q <= LAST;
                    end else begin
                        // next issue is index k+1, i.e. Q(s', k)
                        k_q    <= k_q + K_W'(1);
                        addr_q <= {nxt_q, k_q[A_W-1:0]};
                    end
                end
                LAST: begin
                    state_q <= CALC;
                end
                CALC: begin
                    wr_en_q    <= 1'b1;
                    done_q     <= 1'b1;
                    addr_q     <= {cur_q, act_q};
                    wdata_q    <= new_q_d;
                    q_out_q    <= new_q_d;
                    best_out_q <= best_q;
                    state_q    <= WR;
                end
                WR: begin
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign q_out       = q_out_q;
    assign best_action = best_out_q;
endmodule

// File: tb/tb_q_update_ctrl.sv
// Scoreboard bench for q_update_ctrl: a Q-table shadow predicts each write and
// the read address sequence; a negedge monitor compares whatever the DUT presents.
module tb_q_update_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  cur_state = '0;
    logic [1:0]  action = '0;
    logic [3:0]  next_state = '0;
    logic [15:0] reward = '0;
    logic [5:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [15:0] q_out;
    logic [1:0]  best_action;

    q_update_ctrl #(.S_W(4), .A_W(2), .D_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cur_state(cur_state), .action(action), .next_state(next_state), .reward(reward),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .q_out(q_out), .best_action(best_action)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read, data one cycle after the strobe
    logic [15:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end

    // Reference Q-table, updated only by the model
    logic [15:0] ref_q [0:63];

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic [1:0]  best;
        int          dcyc;
    } exp_t;
    exp_t       exp_q[$];
    logic [5:0] rd_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic set_q(input logic [5:0] a, input logic [15:0] v);
        mem[a] <= v;
        ref_q[a] = v;
    endtask

    // Monitor: compare DUT outputs at the falling edge against scoreboard contents
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (mem_rd_en) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: read of %0h with nothing expected", mem_addr);
                end else begin
                    chk("rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
                end
            end
            if (mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: write %0h to %0h with nothing expected", mem_wdata, mem_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                    chk("done_in_wr", 32'(done), 32'd1);
                    chk("q_out", 32'(q_out), 32'(e.data));
                    chk("best_action", 32'(best_action), 32'(e.best));
                    chk("done_cycle", 32'(cyc), 32'(e.dcyc));
                end
            end else begin
                chk("done_idle", 32'(done), 32'd0);
            end
            if (!mem_rd_en && !mem_wr_en) chk("addr_idle", 32'(mem_addr), 32'd0);
        end
    end

    // One update; inject pulses start in cycles 3 and 5, abort_at asserts rst in that cycle
    task automatic run_op(input logic [3:0] s, input logic [1:0] a, input logic [3:0] ns,
                          input logic [15:0] r, input bit inject, input int abort_at);
        logic [15:0] old, mx;
        logic [1:0]  bst;
        int          cc, nv, c0;
        exp_t        e;
        cur_state = s; action = a; next_state = ns; reward = r; start = 1'b1;
        @(posedge clk); #2;
        c0 = cyc;
        start = 1'b0;

        // Model: greedy max over Q(s',*) with lowest-index tie break, then TD half-step
        old = ref_q[{s, a}];
        mx  = ref_q[{ns, 2'd0}];
        bst = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (ref_q[{ns, 2'(i)}] > mx) begin
                mx  = ref_q[{ns, 2'(i)}];
                bst = 2'(i);
            end
        end
        cc = (int'(r) + int'(mx) / 2 + int'(mx) / 4 + int'(mx) / 8 - int'(old)) & 32'hFFFF;
        nv = (int'(old) + cc / 2) & 32'hFFFF;
        e.addr = {s, a};
        e.data = 16'(nv);
        e.best = bst;
        e.dcyc = c0 + 7;
        exp_q.push_back(e);
        rd_q.push_back({s, a});
        for (int i = 0; i < 4; i++) rd_q.push_back({ns, 2'(i)});
        if (abort_at == 0) ref_q[{s, a}] = 16'(nv);

        for (int k = 1; k <= 8; k++) begin
            if (abort_at != 0 && k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #2;
                rst = 1'b0;
                exp_q.delete();
                rd_q.delete();
                @(negedge clk);
                chk("abort_q_out", 32'(q_out), 32'd0);
                chk("abort_best", 32'(best_action), 32'd0);
                chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
                chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
                @(posedge clk); #2;
                return;
            end
            if (inject && (k == 3 || k == 5)) begin
                start = 1'b1;
                cur_state = 4'($urandom); action = 2'($urandom);
                next_state = 4'($urandom); reward = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #2;
        end
        chk("op_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) set_q(6'(i), 16'h0000);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_q_out", 32'(q_out), 32'd0);
        chk("rst_best", 32'(best_action), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        // All-zero table
        run_op(4'd2, 2'd1, 4'd3, 16'h0100, 1'b0, 0);

        // Tied maximum keeps the lower action index
        set_q({4'd1, 2'd0}, 16'h0100);
        set_q({4'd5, 2'd0}, 16'h0010);
        set_q({4'd5, 2'd1}, 16'h0200);
        set_q({4'd5, 2'd2}, 16'h0040);
        set_q({4'd5, 2'd3}, 16'h0200);
        run_op(4'd1, 2'd0, 4'd5, 16'h0040, 1'b0, 0);

        // Wrapping TD term
        set_q({4'd6, 2'd3}, 16'h8000);
        for (int i = 0; i < 4; i++) set_q({4'd8, 2'(i)}, 16'h0000);
        run_op(4'd6, 2'd3, 4'd8, 16'h0000, 1'b0, 0);

        // Starts while busy are ignored; next op is back-to-back in the cycle after done
        run_op(4'd1, 2'd2, 4'd5, 16'h1234, 1'b1, 0);
        run_op(4'd9, 2'd1, 4'd5, 16'h0F00, 1'b0, 0);

        // Reset in cycle 6 of an operation, then a normal one
        run_op(4'd3, 2'd3, 4'd5, 16'h7777, 1'b0, 6);
        run_op(4'd3, 2'd3, 4'd5, 16'h7777, 1'b0, 0);

        // Same state for s and s'
        set_q({4'd7, 2'd0}, 16'h0100);
        set_q({4'd7, 2'd1}, 16'h0000);
        set_q({4'd7, 2'd2}, 16'h0300);
        set_q({4'd7, 2'd3}, 16'h0000);
        run_op(4'd7, 2'd2, 4'd7, 16'h0000, 1'b0, 0);

        // Randomized table and operations
        for (int i = 0; i < 64; i++) set_q(6'(i), 16'($urandom));
        @(posedge clk); #2;
        for (int n = 0; n < 40; n++) begin
            run_op(4'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                   1'($urandom), 0);
        end
        // Small values force frequent ties in the max search
        for (int i = 0; i < 64; i++) set_q(6'(i), 16'($urandom_range(3, 0)));
        @(posedge clk); #2;
        for (int n = 0; n < 20; n++) begin
            run_op(4'($urandom), 2'($urandom), 4'($urandom), 16'($urandom_range(7, 0)),
                   1'($urandom), 0);
        end

        repeat (3) @(posedge clk);
        chk("final_rd_q_empty", 32'(rd_q.size()), 32'd0);
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
